stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default CLK_FREQ/100 (10 ms), the number of stable cycles required to accept a button level.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_start_stop  input  1  raw asynchronous push-button that toggles run/pause.
REQ-006 btn_clear  input  1  raw asynchronous push-button that clears the counter.
REQ-007 btn_lap  input  1  raw asynchronous push-button that freezes or releases the display.
REQ-008 time_reading  input  8  live BCD {tens, ones} from the counter datapath.
REQ-009 init_regs  output  1  counter clear strobe.
REQ-010 count_enabled  output  1  counter advance enable.
REQ-011 display_reading  output  8  BCD value sent to the display.
REQ-012 running  output  1  high while in RUN.
REQ-013 overflow  output  1  sticky flag: the count wrapped from 99 to 00.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-015 Each debouncer SHALL emit a one-cycle press pulse on every accepted 0->1 transition; a held button SHALL produce exactly one pulse.
REQ-016 The FSM SHALL have four states: INIT, IDLE, RUN and PAUSE.
REQ-017 INIT SHALL go to IDLE after exactly one cycle, unconditionally.
REQ-018 IDLE + start_stop pulse -> RUN; RUN + start_stop pulse -> PAUSE; PAUSE + start_stop pulse -> RUN.
REQ-019 IDLE or PAUSE + clear pulse -> INIT; a clear pulse in RUN SHALL be ignored.
REQ-020 Simultaneous start_stop and clear pulses: in IDLE or PAUSE, clear wins; in RUN, start_stop wins.
REQ-021 All outputs SHALL be registered and decoded from the current state: init_regs=1 only in INIT; count_enabled=1 and running=1 only in RUN.
REQ-022 Latency: a press pulse in cycle N SHALL change the state, and the outputs, at cycle N+1.
REQ-023 Overflow SHALL be set when the registered previous time_reading is 8'h99, the current value is 8'h00, and the state is RUN.
REQ-024 Overflow SHALL remain set until INIT.
REQ-025 Overflow SHALL NOT stop counting.

Reset
REQ-026 While rst_n=0, the block SHALL force: state=INIT, init_regs=1, count_enabled=0, running=0, overflow=0, lap hold cleared, and all debouncer state and counters cleared to 0.
REQ-027 After rst_n deasserts, the first clock edge SHALL leave INIT for IDLE, giving the counter one init_regs cycle.
REQ-028 A reset asserted mid-operation SHALL behave identically to reset from power-up.

Configuration
REQ-029 Macro STOPWATCH_LAP_EN defined: a lap pulse in RUN or PAUSE SHALL toggle lap_hold.
REQ-030 With STOPWATCH_LAP_EN defined, on lap_hold set the display SHALL capture time_reading and hold it; on lap_hold clear the display SHALL track time_reading live; INIT SHALL clear lap_hold.
REQ-031 Macro STOPWATCH_LAP_EN undefined: btn_lap SHALL remain a port but be ignored, and display_reading SHALL equal time_reading, registered with one-cycle latency in both builds.

Structure
REQ-032 A shared package stopwatch_pkg SHALL hold the state enumeration and the default CLK_FREQ and DEBOUNCE_CYCLES constants.
REQ-033 One sub-module, btn_debounce (synchronizer, stable-count counter and edge pulse), SHALL be instantiated three times.
REQ-034 Counter arithmetic SHALL use the Lim_Inc limited incrementer already used in the datapath.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-035 Assert and release reset -> init_regs=1 for exactly one cycle after release; state IDLE; count_enabled=0.
REQ-036 start_stop held high for 20 cycles -> exactly one pulse; count_enabled rises 7 cycles after the button rises (2 sync + 4 stable + 1 registered output) and stays high after release.
REQ-037 A 2-cycle glitch on btn_clear in PAUSE -> no state change and no init_regs.
REQ-038 start_stop and clear pressed in the same cycle while in PAUSE -> INIT, then IDLE; in RUN -> PAUSE, with init_regs staying 0.
REQ-039 Drive time_reading 8'h99 then 8'h00 while in RUN -> overflow=1 on the next cycle; it holds through PAUSE and clears only after clear -> INIT.
REQ-040 With STOPWATCH_LAP_EN: lap pulse at time_reading=8'h42 -> display_reading holds 8'h42 while time_reading advances; a second lap pulse -> display tracks the live value again.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and default timing constants.
// Used by stopwatch_ctrl and btn_debounce.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam int unsigned CLK_FREQ_DEF        = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_FREQ_DEF / 100;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-sample counter and one-cycle press pulse
// on each accepted 0->1 transition of a raw push-button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] lim_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v < lim) ? v + CNT_W'(1) : v;
  endfunction

  logic [1:0]       sync_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // A differing sample advances the run; the level flips on the last sample of a full run.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d   = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = lim_inc(cnt_q, CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM (INIT/IDLE/RUN/PAUSE) with debounced buttons, sticky overflow
// and registered display path; STOPWATCH_LAP_EN adds the lap-hold display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = CLK_FREQ_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [7:0] time_reading,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [7:0] display_reading,
  output logic       running,
  output logic       overflow
);

  logic      ss_pulse, clr_pulse, lap_pulse;
  sw_state_e state_q, state_d;
  logic      init_regs_q, count_en_q, running_q;
  logic      overflow_q, overflow_d;
  logic [7:0] prev_time_q;
  logic [7:0] disp_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_start_stop), .pulse_o(ss_pulse)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clear), .pulse_o(clr_pulse)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_lap), .pulse_o(lap_pulse)
  );

  // Clear beats start/stop when stopped; in RUN only start/stop is honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_IDLE;
      ST_IDLE:  if (clr_pulse) state_d = ST_INIT; else if (ss_pulse) state_d = ST_RUN;
      ST_RUN:   if (ss_pulse)  state_d = ST_PAUSE;
      ST_PAUSE: if (clr_pulse) state_d = ST_INIT; else if (ss_pulse) state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (state_d == ST_INIT) begin
      overflow_d = 1'b0;
    end else if (state_q == ST_RUN && prev_time_q == 8'h99 && time_reading == 8'h00) begin
      overflow_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_regs_q <= 1'b1;
      count_en_q  <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
      prev_time_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      init_regs_q <= (state_d == ST_INIT);
      count_en_q  <= (state_d == ST_RUN);
      running_q   <= (state_d == ST_RUN);
      overflow_q  <= overflow_d;
      prev_time_q <= time_reading;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_hold_q, lap_hold_d;

  always_comb begin
    lap_hold_d = lap_hold_q;
    if (state_q == ST_INIT) begin
      lap_hold_d = 1'b0;
    end else if (lap_pulse && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_hold_d = ~lap_hold_q;
    end
  end

  // The display reloads on the edge that sets the hold, then freezes until it clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold_q <= 1'b0;
      disp_q     <= 8'h00;
    end else begin
      lap_hold_q <= lap_hold_d;
      if (!(lap_hold_d && lap_hold_q)) begin
        disp_q <= time_reading;
      end
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 8'h00;
    end else begin
      disp_q <= time_reading;
    end
  end
`endif

  assign init_regs       = init_regs_q;
  assign count_enabled   = count_en_q;
  assign running         = running_q;
  assign overflow        = overflow_q;
  assign display_reading = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; define STOPWATCH_LAP_EN
// to exercise the lap-hold build.
module tb_stopwatch_ctrl;

  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_CTRL = 12'hF00;
  localparam logic [11:0] M_INIT = 12'h800;

  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] exp;
    logic [11:0] msk;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [7:0] time_reading = 8'h00;
  logic       init_regs, count_enabled, running, overflow;
  logic [7:0] display_reading;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  sb_t sb[$];

  stopwatch_ctrl #(.CLK_FREQ(400), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .time_reading   (time_reading),
    .init_regs      (init_regs),
    .count_enabled  (count_enabled),
    .display_reading(display_reading),
    .running        (running),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void push_exp(input int dc, input string tag,
                                   input logic [11:0] e, input logic [11:0] m);
    sb_t it;
    int  i;
    it.cyc = cyc + dc;
    it.tag = tag;
    it.exp = e;
    it.msk = m;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > it.cyc) i--;
    sb.insert(i, it);
  endfunction

  always @(negedge clk) begin : monitor
    sb_t e;
    logic [11:0] obs;
    obs = {init_regs, count_enabled, running, overflow, display_reading};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_val(e.tag, obs & e.msk, e.exp & e.msk);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_btn(input int sel, input logic v);
    case (sel)
      0: btn_start_stop = v;
      1: btn_clear      = v;
      default: btn_lap  = v;
    endcase
  endtask

  task automatic press(input int sel, input int hold);
    drive_btn(sel, 1'b1);
    tick(hold);
    drive_btn(sel, 1'b0);
    tick(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(2);
    push_exp(1, "rst_hold", 12'h800, M_ALL);
    tick(1);
    rst_n = 1'b1;
    push_exp(1, "rst_release", 12'h000, M_ALL);
    tick(2);

    // 99 -> 00 outside RUN must not flag overflow
    time_reading = 8'h99;
    tick(1);
    time_reading = 8'h00;
    push_exp(1, "ovf_idle", 12'h000, M_ALL);
    tick(2);

    push_exp(6,  "ss_pre",     12'h000, M_CTRL);
    push_exp(7,  "ss_run",     12'h600, M_CTRL);
    push_exp(19, "ss_held",    12'h600, M_CTRL);
    push_exp(29, "ss_release", 12'h600, M_CTRL);
    press(0, 20);

    push_exp(6, "pause_pre", 12'h600, M_CTRL);
    push_exp(7, "pause",     12'h000, M_CTRL);
    press(0, 8);

    for (int i = 1; i <= 10; i++) push_exp(i, "clr_glitch", 12'h000, M_CTRL);
    btn_clear = 1'b1;
    tick(2);
    btn_clear = 1'b0;
    tick(10);

    push_exp(7, "resume", 12'h600, M_CTRL);
    press(0, 8);

    push_exp(7, "clr_in_run",  12'h600, M_CTRL);
    push_exp(9, "clr_in_run2", 12'h600, M_CTRL);
    press(1, 8);

    time_reading = 8'h98;
    tick(1);
    time_reading = 8'h99;
    push_exp(1, "ovf_pre", 12'h699, M_ALL);
    tick(1);
    time_reading = 8'h00;
    push_exp(1, "ovf_set", 12'h700, M_ALL);
    tick(1);
    time_reading = 8'h01;
    push_exp(3, "ovf_still_counting", 12'h701, M_ALL);
    tick(4);

    push_exp(7, "ovf_pause", 12'h100, M_CTRL);
    press(0, 8);

    push_exp(6, "both_pause_pre",  12'h100, M_CTRL);
    push_exp(7, "both_pause_init", 12'h800, M_CTRL);
    push_exp(8, "both_pause_idle", 12'h000, M_CTRL);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    tick(8);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    tick(10);

    push_exp(7, "run_again", 12'h600, M_CTRL);
    press(0, 8);

    push_exp(6, "both_run_pre",   12'h600, M_CTRL);
    push_exp(7, "both_run_pause", 12'h000, M_CTRL);
    for (int i = 1; i <= 10; i++) push_exp(i, "both_run_no_init", 12'h000, M_INIT);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    tick(8);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    tick(10);

    // Reset mid-operation (from PAUSE)
    time_reading = 8'h37;
    tick(1);
    rst_n = 1'b0;
    push_exp(1, "mid_rst", 12'h800, M_ALL);
    tick(2);
    rst_n = 1'b1;
    push_exp(1, "mid_rst_release", 12'h037, M_ALL);
    tick(2);

    push_exp(7, "run_lap", 12'h600, M_CTRL);
    press(0, 8);

    time_reading = 8'h42;
    btn_lap = 1'b1;
    push_exp(7, "lap_capture", 12'h642, M_ALL);
    tick(8);
    time_reading = 8'h50;
    btn_lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    push_exp(1, "lap_hold1", 12'h642, M_ALL);
`else
    push_exp(1, "lap_ignored1", 12'h650, M_ALL);
`endif
    tick(1);
    time_reading = 8'h51;
`ifdef STOPWATCH_LAP_EN
    push_exp(1, "lap_hold2", 12'h642, M_ALL);
`else
    push_exp(1, "lap_ignored2", 12'h651, M_ALL);
`endif
    tick(10);

    time_reading = 8'h55;
    btn_lap = 1'b1;
`ifdef STOPWATCH_LAP_EN
    push_exp(6, "lap_release_pre", 12'h642, M_ALL);
`else
    push_exp(6, "lap_ignored3", 12'h655, M_ALL);
`endif
    push_exp(7, "lap_release", 12'h655, M_ALL);
    tick(8);
    time_reading = 8'h56;
    btn_lap = 1'b0;
    push_exp(1, "lap_live", 12'h656, M_ALL);
    tick(10);

    tick(2);
    check_val("sb_empty", 12'(sb.size()), 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
